// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MEM-stage load/store responder driving a byte-serial 8-bit synchronous RAM
// Optional feature macro: MEM_CTRL_ALIGN_CHK_EN (misaligned requests complete immediately, no RAM access)
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        read_i,
    input  logic [31:0]       read_addr_i,
    input  logic [1:0]        write_i,
    input  logic [31:0]       write_addr_i,
    input  logic [31:0]       write_data_i,
    output logic              read_busy_o,
    output logic              write_busy_o,
    output logic              finish_o,
    output logic [31:0]       read_data_o,
    output logic              misalign_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o
);

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         last_q, last_d;   // byte count minus one
    logic [1:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [1:0]         lane;
    logic               rd_valid;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^{read_addr_i[31:ADDR_W], write_addr_i[31:ADDR_W]};
    assign rd_valid = (read_i != 3'd0) && (read_i <= 3'd5);

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] last,
                                           input logic sgn);
        case (last)
            2'd0:    extend = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
            2'd1:    extend = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

`ifdef MEM_CTRL_ALIGN_CHK_EN
    logic mis_q, mis_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        lane    = cnt_q - 2'd1;
`ifdef MEM_CTRL_ALIGN_CHK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (write_i != 2'd0) begin
                    state_d = WR;
                    addr_d  = write_addr_i[ADDR_W-1:0];
                    wdata_d = write_data_i;
                    last_d  = (write_i == 2'd1) ? 2'd0 : (write_i == 2'd2) ? 2'd1 : 2'd3;
                    sign_d  = 1'b0;
                end else if (rd_valid) begin
                    state_d = RD;
                    addr_d  = read_addr_i[ADDR_W-1:0];
                    rbuf_d  = 32'd0;
                    last_d  = (read_i == 3'd1 || read_i == 3'd4) ? 2'd0 :
                              (read_i == 3'd3) ? 2'd3 : 2'd1;
                    sign_d  = (read_i == 3'd1) || (read_i == 3'd2);
                end
`ifdef MEM_CTRL_ALIGN_CHK_EN
                mis_d = 1'b0;
                if (state_d != IDLE) begin
                    mis_d = ((last_d == 2'd1) && addr_d[0]) ||
                            ((last_d == 2'd3) && (addr_d[1:0] != 2'd0));
                    if (mis_d) begin
                        if (state_d == RD) begin
                            rdata_d = 32'd0;
                        end
                        state_d = DONE;
                    end
                end
`endif
            end
            RD: begin
                // RAM data lags the address by one cycle, so this edge holds the previous lane
                if (cnt_q != 2'd0) begin
                    rbuf_d[{lane, 3'b000} +: 8] = mem_din_i;
                end
                if (cnt_q == last_q) begin
                    state_d = RD_LAST;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD_LAST: begin
                rbuf_d[{last_q, 3'b000} +: 8] = mem_din_i;
                rdata_d = extend(rbuf_d, last_q, sign_q);
                state_d = DONE;
            end
            WR: begin
                if (cnt_q == last_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            last_q  <= 2'd0;
            cnt_q   <= 2'd0;
            sign_q  <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
`ifdef MEM_CTRL_ALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // All outputs decode from registered state so reset clears them immediately
    assign read_busy_o  = (state_q == RD) || (state_q == RD_LAST) || (state_q == WR);
    assign write_busy_o = read_busy_o;
    assign finish_o     = (state_q == DONE);
    assign read_data_o  = rdata_q;
    assign mem_wr_o     = (state_q == WR);
    assign mem_a_o      = ((state_q == RD) || (state_q == WR)) ? addr_q + ADDR_W'(cnt_q) : '0;
    assign mem_dout_o   = (state_q == WR) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
    assign misalign_o   = (state_q == DONE) && mis_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule
